wave_rate_ctrl: RTL and testbench

//  Rate/sequence controller in front of the waveform address generator.

---
 rtl/wave_rate_ctrl_pkg.sv | 25 ++
 rtl/wave_rate_ctrl_if.sv | 40 ++++
 rtl/wave_rate_ctrl_key_debounce.sv | 58 +++++
 rtl/wave_rate_ctrl.sv | 109 ++++++++++
 tb/tb_wave_rate_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_rate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wave_ctrl_pkg
//  Description : Shared encodings and helpers for the waveform rate
//                controller (FSM state codes, default step count, step
//                decode).
//  Revision    : 1.0 - initial release
// ============================================================================
package wave_ctrl_pkg;

    // Controller states, 2-bit encoding shared by the FSM and its return slot
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    // Default number of rate settings
    localparam int NUM_STEPS_DEF = 5;

    // Address increment for a given rate index: one more than the index
    function automatic logic [3:0] step_of(input logic [2:0] idx);
        return {1'b0, idx} + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_rate_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : wave_rate_ctrl_if
//  Description : Front-panel key inputs and generator sequencing outputs of
//                the waveform rate controller. The slave modport is the
//                controller side, the master modport the surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wave_rate_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              speed_n;
    logic              hold_n;
    logic [2:0]        step_idx;
    logic [ADDR_W-1:0] addr_step;
    logic              addr_en;
    logic              addr_clr;
    logic              running;

    modport slave (
        input  speed_n,
        input  hold_n,
        output step_idx,
        output addr_step,
        output addr_en,
        output addr_clr,
        output running
    );

    modport master (
        output speed_n,
        output hold_n,
        input  step_idx,
        input  addr_step,
        input  addr_en,
        input  addr_clr,
        input  running
    );
endinterface
`default_nettype wire

// File: rtl/wave_rate_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Synchronises one raw active-low key into the clock domain,
//                accepts a new level only after it has been steady for
//                DEBOUNCE_CYCLES samples, and pulses press for one cycle
//                when the accepted level falls (key pushed).
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic key_n,
    output logic      stable,
    output logic      press
);

    localparam int             CNT_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchroniser, then count consecutive samples that disagree
    // with the accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_press;

endmodule
`default_nettype wire

// File: rtl/wave_rate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wave_rate_ctrl
//  Description : Rate/sequence controller for the waveform address
//                generator. Debounces the SPEED and HOLD keys, cycles the
//                address increment, and issues advance / phase-restart
//                strobes. Holds no address of its own.
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_rate_ctrl
    import wave_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_STEPS       = NUM_STEPS_DEF,
    parameter int TICK_DIV        = 1,
    parameter int ADDR_W          = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    wave_rate_ctrl_if.slave  bus
);

    localparam int               DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [2:0]       c_IDX_LAST = 3'(NUM_STEPS - 1);

    logic             w_speed_press;
    logic             w_hold_press;
    logic             w_unused_speed_stable;
    logic             w_unused_hold_stable;
    logic [2:0]       w_next_idx;

    logic [1:0]       r_state;
    logic [1:0]       r_ret;
    logic [2:0]       r_step_idx;
    logic [DIV_W-1:0] r_div_cnt;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_speed_key (
        .clk    (clk),
        .reset  (reset),
        .key_n  (bus.speed_n),
        .stable (w_unused_speed_stable),
        .press  (w_speed_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_hold_key (
        .clk    (clk),
        .reset  (reset),
        .key_n  (bus.hold_n),
        .stable (w_unused_hold_stable),
        .press  (w_hold_press)
    );

    assign w_next_idx = (r_step_idx == c_IDX_LAST) ? 3'd0 : r_step_idx + 3'd1;

    // Rate FSM: SPEED has priority over HOLD; CHANGE lasts one cycle, bumps
    // the rate index on entry and restarts the tick divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_ret      <= ST_RUN;
            r_step_idx <= 3'd0;
            r_div_cnt  <= {DIV_W{1'b0}};
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? {DIV_W{1'b0}}
                                                           : r_div_cnt + DIV_W'(1);
                    if (w_speed_press) begin
                        r_state    <= ST_CHANGE;
                        r_ret      <= ST_RUN;
                        r_step_idx <= w_next_idx;
                    end else if (w_hold_press) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_speed_press) begin
                        r_state    <= ST_CHANGE;
                        r_ret      <= ST_HOLD;
                        r_step_idx <= w_next_idx;
                    end else if (w_hold_press) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_CHANGE: begin
                    r_state   <= r_ret;
                    r_div_cnt <= {DIV_W{1'b0}};
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_div_cnt <= {DIV_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.step_idx  = r_step_idx;
    assign bus.addr_step = ADDR_W'(step_of(r_step_idx));
    assign bus.addr_en   = (r_state == ST_RUN) && (r_div_cnt == c_DIV_LAST);
    assign bus.addr_clr  = (r_state == ST_CHANGE);
    assign bus.running   = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_wave_rate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_rate_ctrl
//  Description : Bench for wave_rate_ctrl. Two instances share keys and
//                reset (TICK_DIV=1 and TICK_DIV=3) and are compared with a
//                behavioural model of the key filter and rate sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_rate_ctrl;

    localparam int DB   = 4;
    localparam int NS   = 5;
    localparam int TD_A = 1;
    localparam int TD_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r_speed_n = 1'b1;
    logic r_hold_n  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    wave_rate_ctrl_if #(.ADDR_W(8)) bus_a ();
    wave_rate_ctrl_if #(.ADDR_W(8)) bus_b ();

    assign bus_a.speed_n = r_speed_n;
    assign bus_a.hold_n  = r_hold_n;
    assign bus_b.speed_n = r_speed_n;
    assign bus_b.hold_n  = r_hold_n;

    wave_rate_ctrl #(.DEBOUNCE_CYCLES(DB), .NUM_STEPS(NS), .TICK_DIV(TD_A), .ADDR_W(8)) dut_a (
        .clk(clk), .reset(rst), .bus(bus_a));
    wave_rate_ctrl #(.DEBOUNCE_CYCLES(DB), .NUM_STEPS(NS), .TICK_DIV(TD_B), .ADDR_W(8)) dut_b (
        .clk(clk), .reset(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    // m_st: 0 run, 1 hold, 2 change. Key history m_win[k][j] = raw level
    // sampled j+1 edges ago. A key level is accepted once the DB most recent
    // synchronised samples (two edges old and older) all disagree with it.
    int m_st = 0, m_ret = 0, m_idx = 0, m_ph_a = 0, m_ph_b = 0;
    bit m_sp = 1'b0, m_hp = 1'b0;
    bit m_stab [2];
    bit m_win  [2][DB+1];

    always @(posedge clk) begin : ref_model
        bit raw [2];
        bit np  [2];
        bit all_diff;
        raw[0] = r_speed_n;
        raw[1] = r_hold_n;
        if (rst) begin
            m_st = 0; m_ret = 0; m_idx = 0; m_ph_a = 0; m_ph_b = 0;
            m_sp = 1'b0; m_hp = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_stab[k] = 1'b1;
                for (int j = 0; j <= DB; j++) m_win[k][j] = 1'b1;
            end
        end else begin
            if (m_st == 2) begin
                m_st = m_ret; m_ph_a = 0; m_ph_b = 0;
            end else begin
                if (m_st == 0) begin
                    m_ph_a = (m_ph_a + 1) % TD_A;
                    m_ph_b = (m_ph_b + 1) % TD_B;
                end
                if (m_sp) begin
                    m_ret = m_st; m_st = 2; m_idx = (m_idx + 1) % NS;
                end else if (m_hp) begin
                    m_st = (m_st == 0) ? 1 : 0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                np[k] = 1'b0;
                all_diff = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (m_win[k][j] == m_stab[k]) all_diff = 1'b0;
                if (all_diff) begin
                    m_stab[k] = ~m_stab[k];
                    np[k] = (m_stab[k] == 1'b0);
                end
                for (int j = DB; j >= 1; j--) m_win[k][j] = m_win[k][j-1];
                m_win[k][0] = raw[k];
            end
            m_sp = np[0];
            m_hp = np[1];
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset(input int n);
        rst = 1'b1; r_speed_n = 1'b1; r_hold_n = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic key_cycle(input bit spd, input bit hld, input int low_len, input int total,
                             output int clr_cnt, output int en_in_clr);
        clr_cnt = 0; en_in_clr = 0;
        for (int c = 0; c < total; c++) begin
            r_speed_n = !(spd && (c < low_len));
            r_hold_n  = !(hld && (c < low_len));
            @(negedge clk);
            if (bus_a.addr_clr) begin
                clr_cnt++;
                if (bus_a.addr_en || bus_b.addr_en) en_in_clr++;
            end
        end
        r_speed_n = 1'b1; r_hold_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        do_reset(3);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.step_idx !== 3'd0) begin n_fail++; $display("FAIL reset_step_idx: got %0d expected 0", bus_a.step_idx); end
            n_checks++;
            if (bus_a.addr_step !== 8'd1) begin n_fail++; $display("FAIL reset_addr_step: got %0d expected 1", bus_a.addr_step); end
            n_checks++;
            if (bus_a.running !== 1'b1) begin n_fail++; $display("FAIL reset_running: got %b expected 1", bus_a.running); end
            n_checks++;
            if (bus_a.addr_en !== 1'b1) begin n_fail++; $display("FAIL reset_addr_en: cycle %0d got %b expected 1", c, bus_a.addr_en); end
            n_checks++;
            if (bus_a.addr_clr !== 1'b0 || bus_b.addr_clr !== 1'b0) begin n_fail++; $display("FAIL reset_addr_clr: got %b/%b expected 0", bus_a.addr_clr, bus_b.addr_clr); end
        end
    endtask

    task automatic test_glitch;
        int clr, eic;
        key_cycle(1'b1, 1'b0, 3, 16, clr, eic);
        n_checks++;
        if (clr !== 0) begin n_fail++; $display("FAIL glitch_clr_count: got %0d expected 0", clr); end
        n_checks++;
        if (bus_a.step_idx !== 3'd0) begin n_fail++; $display("FAIL glitch_step_idx: got %0d expected 0", bus_a.step_idx); end
        key_cycle(1'b1, 1'b0, 10, 24, clr, eic);
        n_checks++;
        if (clr !== 1) begin n_fail++; $display("FAIL long_press_clr_count: got %0d expected 1", clr); end
        n_checks++;
        if (bus_a.step_idx !== 3'd1) begin n_fail++; $display("FAIL long_press_step_idx: got %0d expected 1", bus_a.step_idx); end
        n_checks++;
        if (bus_a.addr_step !== 8'd2) begin n_fail++; $display("FAIL long_press_addr_step: got %0d expected 2", bus_a.addr_step); end
    endtask

    task automatic test_speed_wrap;
        int exp_idx [5] = '{1, 2, 3, 4, 0};
        int clr, eic;
        do_reset(2);
        for (int p = 0; p < 5; p++) begin
            key_cycle(1'b1, 1'b0, 6, 20, clr, eic);
            n_checks++;
            if (clr !== 1) begin n_fail++; $display("FAIL wrap_clr_count: press %0d got %0d expected 1", p, clr); end
            n_checks++;
            if (eic !== 0) begin n_fail++; $display("FAIL wrap_en_in_change: press %0d got %0d expected 0", p, eic); end
            n_checks++;
            if (bus_a.step_idx !== 3'(exp_idx[p])) begin n_fail++; $display("FAIL wrap_step_idx: press %0d got %0d expected %0d", p, bus_a.step_idx, exp_idx[p]); end
            n_checks++;
            if (bus_a.addr_step !== 8'(exp_idx[p] + 1)) begin n_fail++; $display("FAIL wrap_addr_step: press %0d got %0d expected %0d", p, bus_a.addr_step, exp_idx[p] + 1); end
        end
    endtask

    task automatic test_hold;
        int clr, eic;
        key_cycle(1'b0, 1'b1, 6, 20, clr, eic);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus_a.running !== 1'b0 || bus_a.addr_en !== 1'b0 || bus_b.addr_en !== 1'b0) begin
                n_fail++; $display("FAIL hold_paused: run=%b en=%b/%b expected 0/0/0", bus_a.running, bus_a.addr_en, bus_b.addr_en);
            end
        end
        key_cycle(1'b1, 1'b0, 6, 20, clr, eic);
        n_checks++;
        if (clr !== 1) begin n_fail++; $display("FAIL hold_speed_clr: got %0d expected 1", clr); end
        n_checks++;
        if (bus_a.step_idx !== 3'd1) begin n_fail++; $display("FAIL hold_speed_step_idx: got %0d expected 1", bus_a.step_idx); end
        n_checks++;
        if (bus_a.running !== 1'b0 || bus_a.addr_en !== 1'b0) begin n_fail++; $display("FAIL hold_after_change: run=%b en=%b expected 0/0", bus_a.running, bus_a.addr_en); end
        key_cycle(1'b0, 1'b1, 6, 20, clr, eic);
        n_checks++;
        if (bus_a.running !== 1'b1 || bus_a.addr_en !== 1'b1) begin n_fail++; $display("FAIL hold_resume: run=%b en=%b expected 1/1", bus_a.running, bus_a.addr_en); end
    endtask

    task automatic test_simultaneous;
        int clr, eic, exp;
        exp = (m_idx + 1) % NS;
        key_cycle(1'b1, 1'b1, 6, 20, clr, eic);
        n_checks++;
        if (clr !== 1) begin n_fail++; $display("FAIL simul_clr: got %0d expected 1", clr); end
        n_checks++;
        if (bus_a.step_idx !== 3'(exp)) begin n_fail++; $display("FAIL simul_step_idx: got %0d expected %0d", bus_a.step_idx, exp); end
        n_checks++;
        if (bus_a.running !== 1'b1) begin n_fail++; $display("FAIL simul_running: got %b expected 1", bus_a.running); end
    endtask

    task automatic test_tickdiv;
        int waited;
        do_reset(2);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            n_checks++;
            if (bus_b.addr_en !== ((j % TD_B) == TD_B - 1)) begin
                n_fail++; $display("FAIL div3_addr_en: cycle %0d got %b expected %b", j, bus_b.addr_en, (j % TD_B) == TD_B - 1);
            end
        end
        // reset landing on the CHANGE cycle
        r_speed_n = 1'b0;
        waited = 0;
        while (!bus_b.addr_clr && waited < 30) begin
            @(negedge clk);
            waited++;
            if (waited == 6) r_speed_n = 1'b1;
        end
        n_checks++;
        if (!bus_b.addr_clr) begin n_fail++; $display("FAIL div3_change_timeout: got no addr_clr in %0d cycles, expected one", waited); end
        rst = 1'b1; r_speed_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_b.running !== 1'b1 || bus_b.addr_clr !== 1'b0) begin n_fail++; $display("FAIL rst_in_change_state: run=%b clr=%b expected 1/0", bus_b.running, bus_b.addr_clr); end
        n_checks++;
        if (bus_b.step_idx !== 3'd0) begin n_fail++; $display("FAIL rst_in_change_step_idx: got %0d expected 0", bus_b.step_idx); end
        n_checks++;
        if (bus_b.addr_en !== 1'b0) begin n_fail++; $display("FAIL rst_in_change_div: addr_en got %b expected 0", bus_b.addr_en); end
        rst = 1'b0;
    endtask

    task automatic test_random;
        int seg;
        for (int c = 0; c < 1500; c++) begin
            if (seg <= 0) begin
                seg = $urandom_range(1, 12);
                r_speed_n = ($urandom_range(0, 2) != 0);
                r_hold_n  = ($urandom_range(0, 2) != 0);
            end
            seg--;
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            n_checks++;
            if (bus_a.step_idx !== 3'(m_idx) || bus_b.step_idx !== 3'(m_idx)) begin
                n_fail++; $display("FAIL rand_step_idx: cycle %0d got %0d/%0d expected %0d", c, bus_a.step_idx, bus_b.step_idx, m_idx);
            end
            n_checks++;
            if (bus_a.addr_step !== 8'(m_idx + 1) || bus_b.addr_step !== 8'(m_idx + 1)) begin
                n_fail++; $display("FAIL rand_addr_step: cycle %0d got %0d/%0d expected %0d", c, bus_a.addr_step, bus_b.addr_step, m_idx + 1);
            end
            n_checks++;
            if (bus_a.running !== (m_st == 0) || bus_b.running !== (m_st == 0)) begin
                n_fail++; $display("FAIL rand_running: cycle %0d got %b/%b expected %b", c, bus_a.running, bus_b.running, m_st == 0);
            end
            n_checks++;
            if (bus_a.addr_clr !== (m_st == 2) || bus_b.addr_clr !== (m_st == 2)) begin
                n_fail++; $display("FAIL rand_addr_clr: cycle %0d got %b/%b expected %b", c, bus_a.addr_clr, bus_b.addr_clr, m_st == 2);
            end
            n_checks++;
            if (bus_a.addr_en !== (m_st == 0 && m_ph_a == TD_A - 1)) begin
                n_fail++; $display("FAIL rand_addr_en_div1: cycle %0d got %b expected %b", c, bus_a.addr_en, m_st == 0 && m_ph_a == TD_A - 1);
            end
            n_checks++;
            if (bus_b.addr_en !== (m_st == 0 && m_ph_b == TD_B - 1)) begin
                n_fail++; $display("FAIL rand_addr_en_div3: cycle %0d got %b expected %b", c, bus_b.addr_en, m_st == 0 && m_ph_b == TD_B - 1);
            end
        end
        rst = 1'b0; r_speed_n = 1'b1; r_hold_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_speed_wrap();
        test_hold();
        test_simultaneous();
        test_tickdiv();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
